sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter_if.sv | 48 ++++
 rtl/sp_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_sp_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arbiter_if.sv
// rtl/sp_ram_arbiter_if.sv - requester and RAM-side signal bundle for sp_ram_arbiter
// master = requesters plus RAM model, slave = arbiter.
interface sp_ram_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              io_p0_req;
  logic              io_p1_req;
  logic              io_p0_we;
  logic              io_p1_we;
  logic [ADDR_W-1:0] io_p0_addr;
  logic [ADDR_W-1:0] io_p1_addr;
  logic [DATA_W-1:0] io_p0_wdata;
  logic [DATA_W-1:0] io_p1_wdata;
  logic              io_p0_lock;
  logic              io_p1_lock;
  logic              io_p0_gnt;
  logic              io_p1_gnt;
  logic              io_p0_rvalid;
  logic              io_p1_rvalid;
  logic [DATA_W-1:0] io_p0_rdata;
  logic [DATA_W-1:0] io_p1_rdata;
  logic              io_mem_en;
  logic              io_mem_we;
  logic [ADDR_W-1:0] io_mem_addr;
  logic [DATA_W-1:0] io_mem_data;
  logic [DATA_W-1:0] io_mem_q;

  modport slave (
    input  io_p0_req, io_p1_req, io_p0_we, io_p1_we,
    input  io_p0_addr, io_p1_addr, io_p0_wdata, io_p1_wdata,
    input  io_p0_lock, io_p1_lock,
    output io_p0_gnt, io_p1_gnt, io_p0_rvalid, io_p1_rvalid,
    output io_p0_rdata, io_p1_rdata,
    output io_mem_en, io_mem_we, io_mem_addr, io_mem_data,
    input  io_mem_q
  );

  modport master (
    output io_p0_req, io_p1_req, io_p0_we, io_p1_we,
    output io_p0_addr, io_p1_addr, io_p0_wdata, io_p1_wdata,
    output io_p0_lock, io_p1_lock,
    input  io_p0_gnt, io_p1_gnt, io_p0_rvalid, io_p1_rvalid,
    input  io_p0_rdata, io_p1_rdata,
    input  io_mem_en, io_mem_we, io_mem_addr, io_mem_data,
    output io_mem_q
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-port arbiter with lock in front of a single-port RAM
// Define SP_RAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port 0.
module sp_ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  sp_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic              rvalid0_q;
  logic              rvalid0_d;
  logic              rvalid1_q;
  logic              rvalid1_d;
  logic              gnt0;
  logic              gnt1;
  logic              tie_to_p1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  // last_q holds the index of the most recently granted port
  assign tie_to_p1 = ~last_q;

  always_comb begin
    last_d = last_q;
    if (gnt1) begin
      last_d = 1'b1;
    end else if (gnt0) begin
      last_d = 1'b0;
    end
  end
`else
  assign tie_to_p1 = 1'b0;
`endif

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.io_p0_req && bus.io_p1_req) begin
            gnt0 = ~tie_to_p1;
            gnt1 = tie_to_p1;
          end else begin
            gnt0 = bus.io_p0_req;
            gnt1 = bus.io_p1_req;
          end
          if (gnt0 && bus.io_p0_lock) begin
            state_d = OWN0;
          end else if (gnt1 && bus.io_p1_lock) begin
            state_d = OWN1;
          end
        end
        // an owner that stops requesting releases the RAM without a grant this cycle
        OWN0: begin
          gnt0 = bus.io_p0_req;
          if (!(bus.io_p0_req && bus.io_p0_lock)) begin
            state_d = IDLE;
          end
        end
        OWN1: begin
          gnt1 = bus.io_p1_req;
          if (!(bus.io_p1_req && bus.io_p1_lock)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rvalid0_d = gnt0 & ~bus.io_p0_we;
    rvalid1_d = gnt1 & ~bus.io_p1_we;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (gnt0) begin
      mem_we   = bus.io_p0_we;
      mem_addr = bus.io_p0_addr;
      mem_data = bus.io_p0_wdata;
    end else if (gnt1) begin
      mem_we   = bus.io_p1_we;
      mem_addr = bus.io_p1_addr;
      mem_data = bus.io_p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.io_p0_gnt    = gnt0;
  assign bus.io_p1_gnt    = gnt1;
  assign bus.io_mem_en    = gnt0 | gnt1;
  assign bus.io_mem_we    = mem_we;
  assign bus.io_mem_addr  = mem_addr;
  assign bus.io_mem_data  = mem_data;
  // a read whose data lands in a reset cycle is dropped, not reported
  assign bus.io_p0_rvalid = rvalid0_q & ~reset;
  assign bus.io_p1_rvalid = rvalid1_q & ~reset;
  assign bus.io_p0_rdata  = bus.io_mem_q;
  assign bus.io_p1_rdata  = bus.io_mem_q;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - randomized and directed bench for sp_ram_arbiter against a behavioural model
// Honours SP_RAM_ARB_ROUND_ROBIN_EN for the expected tie-break.
module tb_sp_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int VW = 6 + AW + 3 * DW;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // RAM behind the arbiter: one-cycle read latency
  logic [DW-1:0] ram [2**AW] = '{default: '0};
  logic [DW-1:0] mem_q_r = '0;
  assign bus.io_mem_q = mem_q_r;
  always @(posedge clk) begin
    if (bus.io_mem_en) begin
      if (bus.io_mem_we) ram[bus.io_mem_addr] <= bus.io_mem_data;
      else               mem_q_r <= ram[bus.io_mem_addr];
    end
  end

  int total = 0;
  int bad = 0;

  // reference model: owner (-1 none), last-served port, pending read per port
  int            m_owner = -1;
  int            m_last = 1;
  bit            m_pend [2];
  logic [DW-1:0] m_pdata [2];
  logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
  logic [VW-1:0] obs;
  logic [VW-1:0] expv;

  task automatic apply(input bit rst, input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input bit l0, input bit l1);
    bit            rq [2];
    bit            wq [2];
    bit            lq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    bit            rv0, rv1, ewe;
    int            eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er0, er1, or0, or1;
    @(negedge clk);
    reset = rst;
    bus.io_p0_req = r0;  bus.io_p1_req = r1;
    bus.io_p0_we = w0;   bus.io_p1_we = w1;
    bus.io_p0_addr = a0; bus.io_p1_addr = a1;
    bus.io_p0_wdata = d0; bus.io_p1_wdata = d1;
    bus.io_p0_lock = l0; bus.io_p1_lock = l1;
    #1;
    rq[0] = r0; rq[1] = r1; wq[0] = w0; wq[1] = w1; lq[0] = l0; lq[1] = l1;
    aq[0] = a0; aq[1] = a1; dq[0] = d0; dq[1] = d1;
    if (rst)                eg = -1;
    else if (m_owner >= 0)  eg = rq[m_owner] ? m_owner : -1;
    else if (r0 && r1)      eg = (RR && m_last == 0) ? 1 : 0;
    else if (r0)            eg = 0;
    else if (r1)            eg = 1;
    else                    eg = -1;
    ewe = 1'b0; ea = '0; ed = '0;
    if (eg >= 0) begin
      ewe = wq[eg]; ea = aq[eg]; ed = dq[eg];
    end
    rv0 = m_pend[0] && !rst;
    rv1 = m_pend[1] && !rst;
    er0 = rv0 ? m_pdata[0] : '0;
    er1 = rv1 ? m_pdata[1] : '0;
    expv = {eg == 0, eg == 1, eg >= 0, ewe, ea, ed, rv0, rv1, er0, er1};
    or0 = bus.io_p0_rvalid ? bus.io_p0_rdata : '0;
    or1 = bus.io_p1_rvalid ? bus.io_p1_rdata : '0;
    obs = {bus.io_p0_gnt, bus.io_p1_gnt, bus.io_mem_en, bus.io_mem_we, bus.io_mem_addr,
           bus.io_mem_data, bus.io_p0_rvalid, bus.io_p1_rvalid, or0, or1};
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_last = 1;
    end else if (eg >= 0) begin
      m_last = eg;
      if (wq[eg]) ref_mem[aq[eg]] = dq[eg];
      else begin
        m_pend[eg] = 1'b1;
        m_pdata[eg] = ref_mem[aq[eg]];
      end
      m_owner = lq[eg] ? eg : -1;
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 1, 0, 0, 6'd1, 6'd2, 8'h11, 8'h22, 1, 1);
      total++;
      if ({bus.io_p0_gnt, bus.io_p1_gnt, bus.io_mem_en, bus.io_p0_rvalid, bus.io_p1_rvalid} !== 5'b0) begin
        bad++;
        $display("FAIL reset_quiet cyc%0d got=%b want=00000", i,
                 {bus.io_p0_gnt, bus.io_p1_gnt, bus.io_mem_en, bus.io_p0_rvalid, bus.io_p1_rvalid});
      end
    end
    apply(0, 1, 1, 0, 0, 6'd1, 6'd2, 8'h00, 8'h00, 0, 0);
    total++;
    if ({bus.io_p0_gnt, bus.io_p1_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_tie got=%b want=10", {bus.io_p0_gnt, bus.io_p1_gnt});
    end
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL reset_model got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_write_read();
    apply(0, 1, 0, 1, 0, 6'd5, 6'd0, 8'hA5, 8'h00, 0, 0);
    total++;
    if ({bus.io_p0_gnt, bus.io_mem_en, bus.io_mem_we, bus.io_mem_addr, bus.io_mem_data} !== {3'b111, 6'd5, 8'hA5}) begin
      bad++;
      $display("FAIL wr_cycle got=%h want=%h",
               {bus.io_p0_gnt, bus.io_mem_en, bus.io_mem_we, bus.io_mem_addr, bus.io_mem_data}, {3'b111, 6'd5, 8'hA5});
    end
    apply(0, 1, 0, 0, 0, 6'd5, 6'd0, 8'h00, 8'h00, 0, 0);
    total++;
    if ({bus.io_p0_gnt, bus.io_mem_we, bus.io_p0_rvalid} !== 3'b100) begin
      bad++;
      $display("FAIL rd_cycle got=%b want=100", {bus.io_p0_gnt, bus.io_mem_we, bus.io_p0_rvalid});
    end
    apply(0, 0, 0, 0, 0, 6'd0, 6'd0, 8'h00, 8'h00, 0, 0);
    total++;
    if ({bus.io_p0_rvalid, bus.io_p1_rvalid, bus.io_p0_rdata} !== {2'b10, 8'hA5}) begin
      bad++;
      $display("FAIL rd_data got=%h want=%h", {bus.io_p0_rvalid, bus.io_p1_rvalid, bus.io_p0_rdata}, {2'b10, 8'hA5});
    end
  endtask

  task automatic test_tie();
    apply(1, 0, 0, 0, 0, 6'd0, 6'd0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] want;
      apply(0, 1, 1, 0, 0, 6'(i), 6'(i + 8), 8'h00, 8'h00, 0, 0);
      want = (RR && (i % 2 == 1)) ? 2'b01 : 2'b10;
      total++;
      if ({bus.io_p0_gnt, bus.io_p1_gnt} !== want) begin
        bad++;
        $display("FAIL tie cyc%0d got=%b want=%b", i, {bus.io_p0_gnt, bus.io_p1_gnt}, want);
      end
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL tie_model cyc%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_lock();
    logic [1:0] want [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    apply(0, 0, 0, 0, 0, 6'd0, 6'd0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bit p0r = (i >= 1);
      bit p1r = (i <= 3);
      bit p1l = (i <= 2);
      apply(0, p0r, p1r, 0, 0, 6'd3, 6'(10 + i), 8'h00, 8'h00, 0, p1l);
      total++;
      if ({bus.io_p0_gnt, bus.io_p1_gnt} !== want[i]) begin
        bad++;
        $display("FAIL lock cyc%0d got=%b want=%b", i, {bus.io_p0_gnt, bus.io_p1_gnt}, want[i]);
      end
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL lock_model cyc%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_drop();
    logic [1:0] want [3] = '{2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 3; i++) begin
      apply(0, i == 0, i >= 1, 0, 1, 6'd7, 6'd9, 8'h00, 8'h5C, 1, 0);
      total++;
      if ({bus.io_p0_gnt, bus.io_p1_gnt, bus.io_mem_en} !== {want[i], want[i] != 2'b00}) begin
        bad++;
        $display("FAIL drop cyc%0d got=%b want=%b", i,
                 {bus.io_p0_gnt, bus.io_p1_gnt, bus.io_mem_en}, {want[i], want[i] != 2'b00});
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(0, 1, 0, 0, 0, 6'd5, 6'd0, 8'h00, 8'h00, 1, 0);
    apply(1, 1, 1, 0, 1, 6'd5, 6'd4, 8'h00, 8'h33, 1, 0);
    total++;
    if ({bus.io_p0_gnt, bus.io_p1_gnt, bus.io_p0_rvalid} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_rst got=%b want=000", {bus.io_p0_gnt, bus.io_p1_gnt, bus.io_p0_rvalid});
    end
    apply(0, 0, 1, 0, 1, 6'd5, 6'd4, 8'h00, 8'h33, 0, 0);
    total++;
    if ({bus.io_p0_gnt, bus.io_p1_gnt, bus.io_p0_rvalid} !== 3'b010) begin
      bad++;
      $display("FAIL rstmid_after got=%b want=010", {bus.io_p0_gnt, bus.io_p1_gnt, bus.io_p0_rvalid});
    end
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL rstmid_model got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_idle();
    apply(0, 0, 0, 0, 0, 6'd0, 6'd0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 1, 1, 6'(i + 1), 6'(i + 20), 8'hFF, 8'hEE, 1, 1);
      total++;
      if ({bus.io_mem_en, bus.io_mem_we, bus.io_mem_addr, bus.io_mem_data, bus.io_p0_rvalid, bus.io_p1_rvalid} !== '0) begin
        bad++;
        $display("FAIL idle cyc%0d got=%h want=0", i,
                 {bus.io_mem_en, bus.io_mem_we, bus.io_mem_addr, bus.io_mem_data, bus.io_p0_rvalid, bus.io_p1_rvalid});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit rst = ($urandom_range(0, 49) == 0);
      apply(rst, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            1'($urandom), 1'($urandom), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
            8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL random cyc%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.io_p0_req = 1'b0;   bus.io_p1_req = 1'b0;
    bus.io_p0_we = 1'b0;    bus.io_p1_we = 1'b0;
    bus.io_p0_addr = '0;    bus.io_p1_addr = '0;
    bus.io_p0_wdata = '0;   bus.io_p1_wdata = '0;
    bus.io_p0_lock = 1'b0;  bus.io_p1_lock = 1'b0;
    m_pend[0] = 1'b0;       m_pend[1] = 1'b0;
    m_pdata[0] = '0;        m_pdata[1] = '0;
    test_reset();
    test_write_read();
    test_tie();
    test_lock();
    test_drop();
    test_reset_mid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
